// File: rtl/nts_api_byte_master.sv
// nts_api_byte_master
// Byte-stream bus master for the NTS engine external API. Framed read and
// write commands arrive on a valid/ready byte port. Each frame becomes one
// API access, and a response frame goes back on a second byte port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an opcode byte
// ARGS   | collecting address/data bytes, inter-byte timeout running
// ACCESS | single cs cycle on the API
// WAIT   | counting read latency before capturing read data
// TX     | shifting the response frame out on the tx port

module nts_api_byte_master #(
    parameter int          READ_LATENCY = 0,
    parameter logic [23:0] TIMEOUT      = 24'd1_000_000
) (
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_api_cs,
    output logic        o_api_we,
    output logic [11:0] o_api_address,
    output logic [31:0] o_api_write_data,
    input  logic [31:0] i_api_read_data,
    output logic        o_busy
);

    localparam logic [7:0]  OP_WRITE  = 8'h57;
    localparam logic [7:0]  OP_READ   = 8'h52;
    localparam logic [7:0]  RSP_ACK   = 8'h4B;
    localparam logic [7:0]  RSP_DATA  = 8'h44;
    localparam logic [7:0]  RSP_ERR   = 8'h45;
    localparam logic [15:0] WAIT_LOAD = 16'(READ_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, ARGS, ACCESS, WAIT, TX} state_t;

    state_t      state;
    logic        is_write;
    logic [2:0]  arg_cnt;
    // Only AH[3:0] is kept: the upper nibble of the address byte is ignored.
    logic [35:0] args;
    logic [23:0] to_cnt;
    logic [15:0] wait_cnt;
    logic [39:0] resp_sr;
    logic [2:0]  tx_left;
    logic        last_arg;

    // Ready is a pure state decode, held low while reset is applied.
    assign o_rx_ready = ~i_areset & ((state == IDLE) | (state == ARGS));
    assign o_busy     = (state != IDLE);
    assign o_tx_data  = resp_sr[39:32];
    assign last_arg   = is_write ? (arg_cnt == 3'd5) : (arg_cnt == 3'd1);

    // Command sequencer: frame parsing, API access, read wait and response.
    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state            <= IDLE;
            is_write         <= 1'b0;
            arg_cnt          <= 3'd0;
            args             <= 36'd0;
            to_cnt           <= 24'd0;
            wait_cnt         <= 16'd0;
            resp_sr          <= 40'd0;
            tx_left          <= 3'd0;
            o_tx_valid       <= 1'b0;
            o_api_cs         <= 1'b0;
            o_api_we         <= 1'b0;
            o_api_address    <= 12'd0;
            o_api_write_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == OP_WRITE || i_rx_data == OP_READ) begin
                            is_write <= (i_rx_data == OP_WRITE);
                            arg_cnt  <= 3'd0;
                            to_cnt   <= TIMEOUT;
                            state    <= ARGS;
                        end else begin
                            resp_sr    <= {RSP_ERR, 32'd0};
                            tx_left    <= 3'd1;
                            o_tx_valid <= 1'b1;
                            state      <= TX;
                        end
                    end
                end
                ARGS: begin
                    if (i_rx_valid) begin
                        // An arriving byte always wins over an expiring timer.
                        args    <= {args[27:0], i_rx_data};
                        arg_cnt <= arg_cnt + 3'd1;
                        to_cnt  <= TIMEOUT;
                        if (last_arg) begin
                            o_api_cs <= 1'b1;
                            o_api_we <= is_write;
                            if (is_write) begin
                                o_api_address    <= {args[35:32], args[31:24]};
                                o_api_write_data <= {args[23:0], i_rx_data};
                            end else begin
                                o_api_address <= {args[3:0], i_rx_data};
                            end
                            state <= ACCESS;
                        end
                    end else if (TIMEOUT != 24'd0 && to_cnt == 24'd0) begin
                        state <= IDLE;
                    end else if (to_cnt != 24'd0) begin
                        to_cnt <= to_cnt - 24'd1;
                    end
                end
                ACCESS: begin
                    o_api_cs <= 1'b0;
                    o_api_we <= 1'b0;
                    if (is_write) begin
                        resp_sr    <= {RSP_ACK, 32'd0};
                        tx_left    <= 3'd1;
                        o_tx_valid <= 1'b1;
                        state      <= TX;
                    end else if (READ_LATENCY == 0) begin
                        resp_sr    <= {RSP_DATA, i_api_read_data};
                        tx_left    <= 3'd5;
                        o_tx_valid <= 1'b1;
                        state      <= TX;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 16'd0) begin
                        resp_sr    <= {RSP_DATA, i_api_read_data};
                        tx_left    <= 3'd5;
                        o_tx_valid <= 1'b1;
                        state      <= TX;
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
                TX: begin
                    if (i_tx_ready) begin
                        resp_sr <= {resp_sr[31:0], 8'd0};
                        tx_left <= tx_left - 3'd1;
                        if (tx_left == 3'd1) begin
                            o_tx_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nts_api_byte_master.sv
// Testbench for nts_api_byte_master: directed frames plus randomized frames
// and back-pressure, checked every cycle against a frame-level model.

module tb_nts_api_byte_master;

    localparam int          RL = 3;
    localparam logic [23:0] TO = 24'd16;

    logic        i_clk = 1'b0;
    logic        i_areset;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_rx_ready;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready;
    logic        o_api_cs;
    logic        o_api_we;
    logic [11:0] o_api_address;
    logic [31:0] o_api_write_data;
    logic [31:0] i_api_read_data;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    nts_api_byte_master #(.READ_LATENCY(RL), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_areset(i_areset),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
        .o_api_cs(o_api_cs), .o_api_we(o_api_we), .o_api_address(o_api_address),
        .o_api_write_data(o_api_write_data), .i_api_read_data(i_api_read_data),
        .o_busy(o_busy)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // API slave contents: a fixed word at 0x123, a pattern elsewhere.
    function automatic logic [31:0] mem_val(input logic [11:0] a);
        if (a == 12'h123) return 32'hCAFEF00D;
        return {a, 8'h5A, ~a};
    endfunction

    // ---------------- frame-level reference model ----------------
    logic [7:0]  frame[$];
    logic [7:0]  resp[$];
    int          resp_start = 0;
    int          cs_cyc = -1;
    int          idle = 0;
    bit          m_acc = 1'b0;
    bit          m_rdy, m_txv;
    logic [11:0] e_addr = 12'd0;
    logic        e_we = 1'b0;
    logic [31:0] e_wdata = 32'd0;
    logic [31:0] m_rd;

    initial forever begin
        @(posedge i_clk);
        if (i_areset) begin
            frame.delete();
            resp.delete();
            cs_cyc = -1;
            idle   = 0;
            m_acc  = 1'b0;
        end else begin
            m_rdy = (resp.size() == 0);
            m_txv = (resp.size() != 0) && (cyc >= resp_start);
            m_acc = i_rx_valid && m_rdy;
            if (m_txv && i_tx_ready) void'(resp.pop_front());
            if (m_acc) begin
                idle = 0;
                if (frame.size() == 0) begin
                    if (i_rx_data == 8'h57 || i_rx_data == 8'h52) frame.push_back(i_rx_data);
                    else begin
                        resp.push_back(8'h45);
                        resp_start = cyc + 1;
                    end
                end else begin
                    frame.push_back(i_rx_data);
                    if ((frame[0] == 8'h52 && frame.size() == 3) ||
                        (frame[0] == 8'h57 && frame.size() == 7)) begin
                        e_addr = {frame[1][3:0], frame[2]};
                        e_we   = (frame[0] == 8'h57);
                        cs_cyc = cyc + 1;
                        if (e_we) begin
                            e_wdata = {frame[3], frame[4], frame[5], frame[6]};
                            resp.push_back(8'h4B);
                            resp_start = cyc + 2;
                        end else begin
                            m_rd = mem_val(e_addr);
                            resp.push_back(8'h44);
                            resp.push_back(m_rd[31:24]);
                            resp.push_back(m_rd[23:16]);
                            resp.push_back(m_rd[15:8]);
                            resp.push_back(m_rd[7:0]);
                            resp_start = cyc + 2 + RL;
                        end
                        frame.delete();
                    end
                end
            end else if (frame.size() != 0) begin
                // The (TO+1)-th silent cycle of a partial frame drops it.
                idle++;
                if (idle == int'(TO) + 1) frame.delete();
            end
        end
        cyc++;
    end

    // ---------------- per-cycle compare and monitors ----------------
    int          cs_cnt = 0;
    logic [11:0] last_addr = 12'd0;
    logic        last_we = 1'b0;
    logic [31:0] last_wdata = 32'd0;
    logic [7:0]  tx_log[$];
    bit          c_txv, c_cs;

    initial forever begin
        @(negedge i_clk);
        if (i_areset) begin
            check("rx_ready_in_reset", o_rx_ready, 0);
        end else begin
            c_txv = (resp.size() != 0) && (cyc >= resp_start);
            c_cs  = (cyc == cs_cyc);
            check("rx_ready", o_rx_ready, resp.size() == 0);
            check("busy", o_busy, (frame.size() != 0) || (resp.size() != 0));
            check("api_cs", o_api_cs, c_cs);
            check("tx_valid", o_tx_valid, c_txv);
            if (c_cs) begin
                check("api_we", o_api_we, e_we);
                check("api_address", o_api_address, e_addr);
                if (e_we) check("api_write_data", o_api_write_data, e_wdata);
            end else begin
                check("api_we_without_cs", o_api_we, 0);
            end
            if (c_txv) check("tx_data", o_tx_data, resp[0]);
            if (o_api_cs) begin
                cs_cnt++;
                last_addr  = o_api_address;
                last_we    = o_api_we;
                last_wdata = o_api_write_data;
            end
            if (o_tx_valid && i_tx_ready) tx_log.push_back(o_tx_data);
        end
    end

    // ---------------- API slave: data valid RL cycles after cs ----------------
    int          s_left = -1;
    logic [11:0] s_addr = 12'd0;

    initial begin
        i_api_read_data = 32'd0;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_api_cs) begin
                s_addr = o_api_address;
                s_left = RL;
            end else if (s_left >= 0) begin
                s_left--;
            end
            i_api_read_data = (s_left == 0) ? mem_val(s_addr) : {16'hBAD0, 16'($urandom)};
        end
    end

    // ---------------- tx back-pressure: 0 = always ready, 1 = random, 2 = manual ----------------
    int tx_mode = 0;

    initial forever begin
        @(posedge i_clk);
        #1;
        if (tx_mode == 0) i_tx_ready = 1'b1;
        else if (tx_mode == 1) i_tx_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        cycles(gap);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        n = 0;
        do begin
            cycles(1);
            n++;
        end while (!m_acc && n < 200);
        if (!m_acc) check("rx_accept_bound", 0, 1);
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    task automatic send_frame(input logic [55:0] v, input int n, input int max_gap,
                              input int long_idx, input int long_gap);
        for (int i = 0; i < n; i++) begin
            if (i == long_idx) send_byte(v[8*(n-1-i) +: 8], long_gap);
            else send_byte(v[8*(n-1-i) +: 8], (i == 0) ? 0 : $urandom_range(0, max_gap));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((resp.size() != 0 || frame.size() != 0) && n < 1000) begin
            cycles(1);
            n++;
        end
        if (n >= 1000) check("drain_bound", 0, 1);
        cycles(2);
    endtask

    task automatic check_tx(input string name, input logic [39:0] exp, input int n);
        check({name, "_len"}, tx_log.size(), n);
        if (tx_log.size() == n)
            for (int i = 0; i < n; i++) check(name, tx_log[i], exp[8*(n-1-i) +: 8]);
    endtask

    int          c0, n, kind;
    logic [7:0]  op, ah, al;
    logic [31:0] d;

    initial begin
        i_areset   = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        i_tx_ready = 1'b1;
        cycles(4);
        i_areset = 1'b0;
        @(negedge i_clk);
        check("reset_rx_ready", o_rx_ready, 1);
        check("reset_busy", o_busy, 0);
        check("reset_tx_valid", o_tx_valid, 0);
        check("reset_cs", o_api_cs, 0);
        check("reset_addr", o_api_address, 0);
        check("reset_wdata", o_api_write_data, 0);
        @(posedge i_clk);
        #1;

        // Write frame.
        tx_log.delete(); c0 = cs_cnt;
        send_frame(56'h570010DEADBEEF, 7, 0, -1, 0);
        wait_idle();
        check("wr_cs_count", cs_cnt - c0, 1);
        check("wr_we", last_we, 1);
        check("wr_addr", last_addr, 12'h010);
        check("wr_wdata", last_wdata, 32'hDEADBEEF);
        check_tx("wr_resp", 40'h4B, 1);

        // Read frame with delayed read data.
        tx_log.delete(); c0 = cs_cnt;
        send_frame(56'h520123, 3, 0, -1, 0);
        wait_idle();
        check("rd_cs_count", cs_cnt - c0, 1);
        check("rd_we", last_we, 0);
        check("rd_addr", last_addr, 12'h123);
        check_tx("rd_resp", 40'h44CAFEF00D, 5);

        // Bad opcode, then a write whose AH upper nibble must be ignored.
        tx_log.delete(); c0 = cs_cnt;
        send_frame(56'h33, 1, 0, -1, 0);
        wait_idle();
        check("err_cs_count", cs_cnt - c0, 0);
        check_tx("err_resp", 40'h45, 1);
        tx_log.delete();
        send_frame(56'h57F23411223344, 7, 0, -1, 0);
        wait_idle();
        check("ah_mask_addr", last_addr, 12'h234);
        check("ah_mask_wdata", last_wdata, 32'h11223344);
        check_tx("ah_mask_resp", 40'h4B, 1);

        // Timed-out partial frame, then a served read.
        tx_log.delete(); c0 = cs_cnt;
        send_frame(56'h570010, 3, 0, -1, 0);
        cycles(20);
        check("to_busy", o_busy, 0);
        check("to_cs_count", cs_cnt - c0, 0);
        check("to_tx_len", tx_log.size(), 0);
        send_frame(56'h520000, 3, 0, -1, 0);
        wait_idle();
        check("to_next_addr", last_addr, 12'h000);
        check_tx("to_next_resp", 40'h440005AFFF, 5);

        // Byte arriving exactly when the timer expires is accepted.
        tx_log.delete(); c0 = cs_cnt;
        send_frame(56'h570010DEADBEEF, 7, 0, 3, 16);
        wait_idle();
        check("to_edge_cs_count", cs_cnt - c0, 1);
        check("to_edge_wdata", last_wdata, 32'hDEADBEEF);
        check_tx("to_edge_resp", 40'h4B, 1);

        // Random back-pressure on a read response.
        tx_mode = 1;
        tx_log.delete();
        send_frame(56'h520123, 3, 0, -1, 0);
        wait_idle();
        check_tx("bp_resp", 40'h44CAFEF00D, 5);

        // Reset while the third response byte is on offer.
        tx_mode = 2;
        i_tx_ready = 1'b1;
        tx_log.delete(); c0 = cs_cnt;
        send_frame(56'h520123, 3, 0, -1, 0);
        n = 0;
        while (tx_log.size() < 2 && n < 100) begin
            cycles(1);
            n++;
        end
        check("rst_tx_reached", tx_log.size(), 2);
        i_tx_ready = 1'b0;
        i_areset   = 1'b1;
        cycles(2);
        i_areset   = 1'b0;
        @(negedge i_clk);
        check("rst_tx_valid_low", o_tx_valid, 0);
        @(posedge i_clk);
        #1;
        i_tx_ready = 1'b1;
        cycles(20);
        check("rst_no_more_tx", tx_log.size(), 2);
        check("rst_cs_count", cs_cnt - c0, 1);
        tx_mode = 0;
        tx_log.delete();
        send_frame(56'h57ABC000000001, 7, 0, -1, 0);
        wait_idle();
        check("rst_after_addr", last_addr, 12'hBC0);
        check_tx("rst_after_resp", 40'h4B, 1);

        // Randomized frames with back-pressure, gaps and occasional timeouts.
        tx_mode = 1;
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 7);
            ah = 8'($urandom);
            al = 8'($urandom);
            d  = $urandom;
            if (kind <= 2)
                send_frame({8'h57, ah, al, d}, 7, 2, -1, 0);
            else if (kind <= 5)
                send_frame({32'd0, 8'h52, ah, al}, 3, 2, -1, 0);
            else if (kind == 6) begin
                do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
                send_frame({48'd0, op}, 1, 0, -1, 0);
            end else
                send_frame({8'h57, ah, al, d}, 7, 2, $urandom_range(1, 6), $urandom_range(14, 20));
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
